// File: rtl/ysyx_22050550_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050550_fetch_ctrl_if
// Brief    : Fetch controller bundle: redirect, imem request/response, IF out.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22050550_fetch_ctrl_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_inst;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    // master: the fetch controller itself
    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_inst, if_ready,
        output mem_req_valid, mem_req_addr, if_valid, if_pc, if_inst
    );

    // slave: execute / memory / decode environment
    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid,
               mem_rsp_inst, if_ready,
        input  mem_req_valid, mem_req_addr, if_valid, if_pc, if_inst
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050550_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050550_fetch_ctrl
// Brief    : Single-outstanding instruction fetch FSM with redirect/flush.
//            Optional YSYX_22050550_FETCH_PERF_EN adds fetch/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050550_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    ysyx_22050550_fetch_ctrl_if.master       bus
`ifdef YSYX_22050550_FETCH_PERF_EN
    ,
    output logic [63:0]                      fetch_cnt,
    output logic [63:0]                      flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_addr;
    logic        r_drop;
    logic        r_mem_req_valid;
    logic        r_if_valid;
    logic [63:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic [63:0] w_redirect_pc;
    logic [63:0] w_pc_next;

    assign w_redirect_pc = bus.redirect_pc & ~64'd3;
    assign w_pc_next     = r_pc + 64'd4;

    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_addr  = r_req_addr;
    assign bus.if_valid      = r_if_valid;
    assign bus.if_pc         = r_if_pc;
    assign bus.if_inst       = r_if_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_PC;
            r_req_addr      <= RESET_PC;
            r_drop          <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_if_valid      <= 1'b0;
            r_if_pc         <= 64'd0;
            r_if_inst       <= 32'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // req_addr is frozen here; a redirect only retargets pc
                    // and marks the in-flight response for discard.
                    if (bus.redirect_valid) begin
                        r_pc   <= w_redirect_pc;
                        r_drop <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        r_state         <= S_WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop          <= 1'b0;
                            r_state         <= S_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_pc            <= bus.redirect_valid ? w_redirect_pc : r_pc;
                            r_req_addr      <= bus.redirect_valid ? w_redirect_pc : r_pc;
                        end else if (bus.redirect_valid) begin
                            r_state         <= S_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_pc            <= w_redirect_pc;
                            r_req_addr      <= w_redirect_pc;
                        end else begin
                            r_state    <= S_OUT;
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_req_addr;
                            r_if_inst  <= bus.mem_rsp_inst;
                        end
                    end else if (bus.redirect_valid) begin
                        r_pc   <= w_redirect_pc;
                        r_drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid || bus.if_ready) begin
                        r_state         <= S_REQ;
                        r_if_valid      <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_pc            <= bus.redirect_valid ? w_redirect_pc : w_pc_next;
                        r_req_addr      <= bus.redirect_valid ? w_redirect_pc : w_pc_next;
                    end
                end
                default: begin
                    r_state         <= S_REQ;
                    r_mem_req_valid <= 1'b1;
                    r_if_valid      <= 1'b0;
                end
            endcase
        end
    end

`ifdef YSYX_22050550_FETCH_PERF_EN
    logic [63:0] r_fetch_cnt;
    logic [63:0] r_flush_cnt;
    logic        w_fetch_fire;
    logic        w_flush_fire;

    assign w_fetch_fire = r_if_valid && bus.if_ready;
    // Any response arriving in WAIT that does not reach OUT is a flush.
    assign w_flush_fire = (r_state == S_WAIT) && bus.mem_rsp_valid &&
                          (r_drop || bus.redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 64'd0;
            r_flush_cnt <= 64'd0;
        end else begin
            if (w_fetch_fire) r_fetch_cnt <= r_fetch_cnt + 64'd1;
            if (w_flush_fire) r_flush_cnt <= r_flush_cnt + 64'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/ysyx_22050550_fetch_ctrl.md
YSYX_22050550_FETCH_CTRL -- requirements
Module: ysyx_22050550_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 64'h8000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: redirect_valid  in  1  jump/branch/trap redirect request from execute, single-cycle pulse.
REQ-005 Port: redirect_pc  in  64  redirect target.
REQ-006 Port: mem_req_valid  out  1  instruction memory request valid.
REQ-007 Port: mem_req_ready  in  1  memory accepts request this cycle.
REQ-008 Port: mem_req_addr  out  64  fetch address.
REQ-009 Port: mem_rsp_valid  in  1  response valid, one per accepted request, in order.
REQ-010 Port: mem_rsp_inst  in  32  fetched instruction.
REQ-011 Port: if_valid  out  1  fetched pc/inst valid toward IFU/decode.
REQ-012 Port: if_ready  in  1  decode accepts this cycle.
REQ-013 Port: if_pc  out  64  pc of delivered instruction.
REQ-014 Port: if_inst  out  32  delivered instruction.

Function
REQ-015 FSM states SHALL be REQ, WAIT, OUT; at most one request outstanding.
REQ-016 REQ: mem_req_valid=1, mem_req_addr=req_addr register; on mem_req_ready -> WAIT.
REQ-017 mem_req_addr SHALL stay constant while mem_req_valid=1 and mem_req_ready=0, even across redirects.
REQ-018 WAIT: on mem_rsp_valid with drop=0, latch if_pc=req_addr, if_inst=mem_rsp_inst -> OUT.
REQ-019 OUT: if_valid=1, if_pc/if_inst stable until if_ready; on if_ready pc<=pc+4, req_addr<=pc+4 -> REQ.
REQ-020 Minimum latency: request accepted cycle N, response cycle N+1, if_valid cycle N+2.
REQ-021 Redirect SHALL take priority over sequential pc update; pc<=redirect_pc with bits[1:0] cleared.
REQ-022 Redirect in REQ (accepted or not) or WAIT without response: drop<=1; current request completes; its response SHALL be discarded, then -> REQ at new pc.
REQ-023 Redirect in WAIT coincident with mem_rsp_valid: response discarded, drop stays 0, -> REQ at new pc next cycle.
REQ-024 Redirect in OUT: if_valid SHALL deassert next cycle; if if_ready same cycle, transfer counts as accepted; -> REQ at redirect_pc (not pc+4).
REQ-025 Redirect while drop=1: pc updated to latest target, drop remains 1.
REQ-026 Response with drop=1: discarded, drop<=0, -> REQ with req_addr<=pc.
REQ-027 pc+4 SHALL wrap modulo 2^64.
REQ-028 mem_rsp_valid in REQ or OUT is a protocol error; SHALL be ignored.

Reset
REQ-029 On rst=1 at clock edge: state=REQ, pc=req_addr=RESET_PC, drop=0, if_valid=0, if_pc=0, if_inst=0; mem_req_valid=1 from first cycle after rst deasserts; rst mid-transaction abandons outstanding response (memory is reset together).

Configuration
REQ-030 Macro YSYX_22050550_FETCH_PERF_EN: when defined, adds ports fetch_cnt out 64 (count of if_valid&&if_ready transfers) and flush_cnt out 64 (count of discarded responses), both reset to 0, wrapping; when undefined, ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-031 Reset release, mem_req_ready=1, response 1 cycle later, if_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008; one instruction per 3 cycles.
REQ-032 Hold if_ready=0 for 5 cycles in OUT -> if_pc/if_inst stable, no new mem_req_valid.
REQ-033 mem_req_ready=0 for 3 cycles with redirect_valid (0x80001002) in cycle 2 -> mem_req_addr unchanged until accepted; response discarded; next request 0x80001000.
REQ-034 Redirect coincident with mem_rsp_valid -> no if_valid; next request at redirect target; flush_cnt+1 when PERF_EN.
REQ-035 Redirect with if_ready in OUT at pc 0x80000010 -> transfer accepted (fetch_cnt+1), next request redirect_pc, not 0x80000014.
REQ-036 redirect_pc=0xFFFF_FFFF_FFFF_FFFC, sequential fetch -> next address 0x0.
